// File: rtl/mm_pkg.sv
// Shared types and defaults for the matrix-multiply accumulation stage.
package mm_pkg;

  localparam int unsigned MM_N  = 16;
  localparam int unsigned MM_DW = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef logic signed [MM_DW-1:0] lane_t;

endpackage

// File: rtl/mm_out_fifo.sv
// Synchronous output FIFO with registered head; push on full succeeds when a pop lands the same cycle.
module mm_out_fifo #(
  parameter int unsigned W     = 512,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_d;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic [CW-1:0] remain;
  logic          pop_ok;
  logic          push_ok;

  // Qualify requests and work out the occupancy after this edge.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    rd_ptr_d = rd_ptr + AW'(pop_ok);
    remain   = count - CW'(pop_ok);
    count_d  = remain + CW'(push_ok);
  end

  // Storage write; no reset needed since entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, flags and the registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_d;
      count  <= count_d;
      empty  <= (count_d == '0);
      full   <= (count_d == CW'(DEPTH));
      if (push_ok && (remain == '0)) begin
        head <= push_data;
      end else if (remain != '0) begin
        head <= mem[rd_ptr_d];
      end
    end
  end

endmodule

// File: rtl/mm_acc_stage.sv
// Lane-wise accumulation of multiplier partial vectors across K-tiles, optional ReLU, output queue.
module mm_acc_stage
  import mm_pkg::*;
#(
  parameter int unsigned N          = MM_N,
  parameter int unsigned DW         = MM_DW,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW*N-1:0]   in_vec,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              relu_en,
  output logic [DW*N-1:0]   out_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  tile_cnt,
  output logic              overflow,
  output logic              seq_err
);

  localparam int unsigned     VW      = DW * N;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_d;
  logic             start;
  logic             acc_load;
  logic             push;
  logic             seq_hit;
  logic [CNT_W-1:0] tile_cnt_d;
  logic [VW-1:0]    fin_vec;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

  // Next-state, tile counting and beat routing.
  always_comb begin
    state_d    = state;
    acc_load   = 1'b0;
    push       = 1'b0;
    seq_hit    = 1'b0;
    tile_cnt_d = tile_cnt;
    start      = in_first | (state == IDLE);
    if (in_valid) begin
      seq_hit = in_first & (state == ACCUM);
      if (in_last) begin
        push       = 1'b1;
        state_d    = IDLE;
        tile_cnt_d = '0;
      end else begin
        acc_load = 1'b1;
        state_d  = ACCUM;
        if (start) begin
          tile_cnt_d = CNT_W'(1);
        end else if (tile_cnt != CNT_MAX) begin
          tile_cnt_d = tile_cnt + CNT_W'(1);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Per-lane adder, partial-sum register and ReLU select.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] lane_in;
    logic [DW-1:0] lane_sum;
    logic [DW-1:0] acc_q;

    assign lane_in  = in_vec[i*DW +: DW];
    assign lane_sum = start ? lane_in : (acc_q + lane_in);
    assign fin_vec[i*DW +: DW] = (relu_en && lane_sum[DW-1]) ? '0 : lane_sum;

    // Hold the running partial for this lane.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
      end else if (acc_load) begin
        acc_q <= lane_sum;
      end
    end
  end

  assign pop       = ~fifo_empty & out_ready;
  assign drop      = push & fifo_full & ~pop;
  assign out_valid = ~fifo_empty;

  // Tile counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_cnt <= '0;
      overflow <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      tile_cnt <= tile_cnt_d;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (seq_hit) begin
        seq_err <= 1'b1;
      end
    end
  end

  mm_out_fifo #(
    .W     (VW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fin_vec),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_vec)
  );

endmodule

// File: doc/mm_acc_stage.md
# mm_acc_stage

Output accumulation stage directly downstream of the 16-lane matrix-vector multiply unit. Collects the N-lane partial-result vectors the multiplier emits once per K-tile and sums them lane-wise across the tiles of one output block. Optionally applies ReLU and queues finished vectors in a small output FIFO with a valid/ready handshake toward the write-back path. The multiplier has no backpressure, so this stage absorbs its results unconditionally and flags loss when the queue overflows.

## Interface
Parameters:
- N, 16, lanes per vector (must match the multiplier's N)
- DW, 32, lane width in bits, signed two's complement
- FIFO_DEPTH, 4, output queue entries (power of two, ≥2)
- CNT_W, 8, width of tile counter

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_vec  in  DW*N  partial result; lane i at [(i+1)*DW-1 : i*DW]
- in_valid  in  1  in_vec valid this cycle (driven from multiplier add_valid)
- in_first  in  1  qualifies in_valid: first tile of a block
- in_last  in  1  qualifies in_valid: last tile of a block
- relu_en  in  1  sampled on the in_valid & in_last cycle
- out_vec  out  DW*N  head of output FIFO
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- tile_cnt  out  CNT_W  tiles accumulated in the open block
- overflow  out  1  sticky: a finished vector was dropped
- seq_err  out  1  sticky: in_first arrived while a block was open

## Operation
- FSM states: IDLE (no open block), ACCUM (partial sum held in acc[N]).
- Every in_valid beat is accepted; there is no input stall.
- Sum for beat: s = (in_first or state==IDLE) ? in_vec : acc + in_vec, per lane, modulo 2^DW (wrap, no saturation).
- in_valid & !in_last: acc <= s; state -> ACCUM; tile_cnt <= (start ? 1 : tile_cnt+1).
- in_valid & in_last: push f(s) into FIFO, where f = ReLU (negative lanes -> 0) if relu_en, else identity. State -> IDLE; tile_cnt <= 0.
- in_valid without in_first in IDLE: treated as first tile; this is not an error.
- in_first in ACCUM: the old partial is discarded and the block restarts from in_vec. seq_err <= 1.
- in_first & in_last on the same beat: a single-tile block; in_vec goes through f straight to the FIFO.
- Push while full with no pop the same cycle: the vector is dropped, FIFO unchanged, overflow <= 1. Push while full with a pop the same cycle succeeds.
- Pop on out_valid & out_ready. Order is FIFO.
- tile_cnt saturates at 2^CNT_W-1.
- overflow and seq_err clear only on rst.

## Timing
- Reset values: out_valid 0, out_vec 0, tile_cnt 0, overflow 0, seq_err 0, state IDLE, acc 0, FIFO empty.
- Latency: in_valid & in_last at cycle t -> out_valid = 1 and out_vec = result at t+1 (FIFO was empty).
- Throughput: one input beat per cycle sustained, and one output pop per cycle.
- out_vec is registered from FIFO storage and is stable while out_valid & !out_ready.
- rst asserted mid-block: acc, FIFO and flags are cleared at that edge. An in_valid beat in the rst cycle is ignored. out_valid = 0 the following cycle.

## Structure
- Package mm_pkg holds:
  - default N and DW;
  - the typedef enum for the FSM state {IDLE, ACCUM};
  - the lane typedef logic signed [DW-1:0].
- Sub-module mm_out_fifo: a synchronous FIFO of width DW*N, depth FIFO_DEPTH, with registered output. It has ports push, push_data, pop, full, empty, head, with simultaneous push/pop on full supported.
- The accumulator lanes are a generate loop in mm_acc_stage, one adder plus ReLU mux per lane.

## Test plan
- Single-tile block: lane i = i with first & last, relu_en = 0 -> at t+1 out_vec lane i = i, out_valid = 1, tile_cnt = 0.
- Three-tile block: all lanes 1, then 2, then 3 (last on the third beat) -> one output, all lanes 6. tile_cnt reads 1, then 2, during the block.
- ReLU: lanes alternate -5/+5 on a single-tile beat with relu_en = 1 -> 0/+5. The same beat with relu_en = 0 -> -5/+5.
- Wrap: 0x7FFFFFFF then 0x00000001 (2 tiles) -> 0x80000000, overflow stays 0.
- Backpressure: out_ready = 0, five single-tile blocks with values 1..5 -> FIFO holds 1..4 and overflow = 1. Raising out_ready drains 1, 2, 3, 4 in order; then out_valid = 0.
- Errors and reset:
  - in_first while in ACCUM -> seq_err = 1 and the block restarts; the final sum excludes the old partial.
  - rst pulsed after two tiles -> all outputs at reset values. The next last-beat block produces only its own sum.
